// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin arbiter/sequencer for the APB master command port
// Optional ISSUE timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
   parameter int AW      = 9,
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic          pclk,
   input  logic          presetn,
   input  logic          req0,
   input  logic          req1,
   input  logic          rw0,
   input  logic          rw1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic          psel,
   input  logic          penable,
   input  logic          pready,
   input  logic [DW-1:0] apb_read_data_out,
   output logic          transfer,
   output logic          read_write,
   output logic [AW-1:0] apb_write_paddr,
   output logic [AW-1:0] apb_read_paddr,
   output logic [DW-1:0] apb_write_data,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("apb_req_arbiter: TIMEOUT must be in 2..255");
   end

   state_t        state;
   logic          cmd_rw;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          owner;
   logic          last_grant;
   logic          grant;
   logic          complete;

`ifdef APB_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt;
   logic       err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // On contention the requester that did not win last time is served.
   assign grant    = (req0 & req1) ? ~last_grant : req1;
   assign complete = psel & penable & pready;

   assign read_write      = cmd_rw;
   assign apb_write_paddr = cmd_rw ? '0 : cmd_addr;
   assign apb_read_paddr  = cmd_rw ? cmd_addr : '0;
   assign apb_write_data  = cmd_rw ? '0 : cmd_wdata;
   assign busy            = (state != IDLE);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state      <= IDLE;
         cmd_rw     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         transfer   <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         rdata      <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         cnt        <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req0 | req1) begin
                  owner     <= grant;
                  cmd_rw    <= grant ? rw1 : rw0;
                  cmd_addr  <= grant ? addr1 : addr0;
                  cmd_wdata <= grant ? wdata1 : wdata0;
                  transfer  <= 1'b1;
                  state     <= ISSUE;
`ifdef APB_ARB_TIMEOUT_EN
                  cnt       <= '0;
`endif
               end
            end
            ISSUE: begin
               if (complete) begin
                  rdata    <= cmd_rw ? apb_read_data_out : '0;
                  transfer <= 1'b0;
                  done0    <= ~owner;
                  done1    <= owner;
                  state    <= DONE;
               end
`ifdef APB_ARB_TIMEOUT_EN
               else if (cnt == TO_LAST) begin
                  rdata    <= '0;
                  err_q    <= 1'b1;
                  transfer <= 1'b0;
                  done0    <= ~owner;
                  done1    <= owner;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
`endif
            end
            DONE: begin
               done0      <= 1'b0;
               done1      <= 1'b0;
               last_grant <= owner;
               state      <= IDLE;
`ifdef APB_ARB_TIMEOUT_EN
               err_q      <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed self-checking bench for apb_req_arbiter
// Timeout checks follow APB_ARB_TIMEOUT_EN.
module tb_apb_req_arbiter;

   localparam int AW = 9;
   localparam int DW = 8;

   logic          pclk = 1'b0;
   logic          presetn;
   logic          req0, req1, rw0, rw1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          psel, penable, pready;
   logic [DW-1:0] apb_read_data_out;
   logic          transfer, read_write;
   logic [AW-1:0] apb_write_paddr, apb_read_paddr;
   logic [DW-1:0] apb_write_data, rdata;
   logic          done0, done1, err, busy;

   int errors = 0;
   int checks = 0;

   apb_req_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
      .pclk(pclk), .presetn(presetn),
      .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .psel(psel), .penable(penable), .pready(pready),
      .apb_read_data_out(apb_read_data_out),
      .transfer(transfer), .read_write(read_write),
      .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
      .apb_write_data(apb_write_data),
      .done0(done0), .done1(done1), .rdata(rdata), .err(err), .busy(busy)
   );

   always #5 pclk = ~pclk;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic apb_idle();
      psel = 1'b0; penable = 1'b0; pready = 1'b0;
   endtask

   task automatic test_reset();
      presetn = 1'b0;
      req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      apb_read_data_out = '0;
      apb_idle();
      tick(); tick();
      checks++;
      if ({transfer, read_write, apb_write_paddr, apb_read_paddr, apb_write_data, done0, done1, rdata, err, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got tr=%b rw=%b wa=%h ra=%h wd=%h d0=%b d1=%b rd=%h err=%b busy=%b, expected all 0",
                  transfer, read_write, apb_write_paddr, apb_read_paddr, apb_write_data, done0, done1, rdata, err, busy);
      end
      presetn = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (transfer !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release_idle: got transfer=%b busy=%b, expected 0 0", transfer, busy);
      end
   endtask

   task automatic test_single_write();
      req0 = 1; rw0 = 0; addr0 = 9'h012; wdata0 = 8'hA5;
      tick();
      checks++;
      if ({transfer, busy, read_write, apb_write_paddr, apb_write_data, apb_read_paddr} !== {1'b1, 1'b1, 1'b0, 9'h012, 8'hA5, 9'h000}) begin
         errors++;
         $display("FAIL write_issue: got tr=%b busy=%b rw=%b wa=%h wd=%h ra=%h, expected 1 1 0 012 a5 000",
                  transfer, busy, read_write, apb_write_paddr, apb_write_data, apb_read_paddr);
      end
      psel = 1;
      tick();
      checks++;
      if (transfer !== 1'b1 || done0 !== 1'b0) begin
         errors++; $display("FAIL write_setup_hold: got transfer=%b done0=%b, expected 1 0", transfer, done0);
      end
      penable = 1; pready = 1;
      tick();
      checks++;
      if ({done0, done1, err, transfer, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL write_done: got d0=%b d1=%b err=%b tr=%b rd=%h, expected 1 0 0 0 00", done0, done1, err, transfer, rdata);
      end
      apb_idle(); req0 = 0;
      tick();
      checks++;
      if (done0 !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL write_done_pulse_width: got done0=%b busy=%b, expected 0 0", done0, busy);
      end
   endtask

   task automatic test_single_read();
      req1 = 1; rw1 = 1; addr1 = 9'h105; wdata1 = 8'hEE;
      tick();
      checks++;
      if ({transfer, read_write, apb_read_paddr, apb_write_paddr, apb_write_data} !== {1'b1, 1'b1, 9'h105, 9'h000, 8'h00}) begin
         errors++;
         $display("FAIL read_issue: got tr=%b rw=%b ra=%h wa=%h wd=%h, expected 1 1 105 000 00",
                  transfer, read_write, apb_read_paddr, apb_write_paddr, apb_write_data);
      end
      psel = 1;
      tick();
      penable = 1; pready = 1; apb_read_data_out = 8'h3C;
      tick();
      checks++;
      if ({done1, done0, err, transfer, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h3C}) begin
         errors++;
         $display("FAIL read_done: got d1=%b d0=%b err=%b tr=%b rd=%h, expected 1 0 0 0 3c", done1, done0, err, transfer, rdata);
      end
      apb_idle(); req1 = 0; apb_read_data_out = '0;
      tick();
      checks++;
      if (done1 !== 1'b0) begin
         errors++; $display("FAIL read_done_pulse_width: got done1=%b, expected 0", done1);
      end
   endtask

   task automatic test_idle_completion();
      psel = 1; penable = 1; pready = 1;
      tick(); tick();
      checks++;
      if ({done0, done1, transfer, busy} !== 4'b0000) begin
         errors++; $display("FAIL idle_completion_ignored: got d0=%b d1=%b tr=%b busy=%b, expected 0000", done0, done1, transfer, busy);
      end
      apb_idle();
   endtask

   task automatic test_contention();
      int exp_owner;
      int n;
      rw0 = 0; addr0 = 9'h0AA; wdata0 = 8'h11;
      rw1 = 0; addr1 = 9'h155; wdata1 = 8'h22;
      req0 = 1; req1 = 1;
      for (int k = 0; k < 4; k++) begin
         exp_owner = k % 2;
         n = 0;
         while (transfer !== 1'b1 && n < 10) begin tick(); n++; end
         checks++;
         if (transfer !== 1'b1) begin
            errors++; $display("FAIL contention_wait_%0d: got transfer=%b, expected 1 within 10 cycles", k, transfer);
         end
         checks++;
         if (apb_write_paddr !== (exp_owner == 0 ? 9'h0AA : 9'h155)) begin
            errors++; $display("FAIL contention_grant_%0d: got addr=%h, expected %h", k, apb_write_paddr, (exp_owner == 0 ? 9'h0AA : 9'h155));
         end
         psel = 1;
         tick();
         penable = 1; pready = 1;
         tick();
         checks++;
         if ({done0, done1} !== (exp_owner == 0 ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL contention_done_%0d: got d0d1=%b%b, expected owner %0d", k, done0, done1, exp_owner);
         end
         apb_idle();
         tick();
         checks++;
         if ({done0, done1, transfer} !== 3'b000) begin
            errors++; $display("FAIL contention_gap_%0d: got d0=%b d1=%b tr=%b, expected 000", k, done0, done1, transfer);
         end
      end
      req0 = 0; req1 = 0;
      tick(); tick();
   endtask

   task automatic test_reset_mid_issue();
      req0 = 1; rw0 = 1; addr0 = 9'h033;
      tick();
      checks++;
      if (transfer !== 1'b1) begin
         errors++; $display("FAIL midrst_issue: got transfer=%b, expected 1", transfer);
      end
      #2 presetn = 0;
      #1;
      checks++;
      if (transfer !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_async_drop: got transfer=%b busy=%b, expected 0 0", transfer, busy);
      end
      tick(); tick();
      checks++;
      if (done0 !== 1'b0 || done1 !== 1'b0) begin
         errors++; $display("FAIL midrst_no_done: got d0=%b d1=%b, expected 0 0", done0, done1);
      end
      #2 presetn = 1;
      tick();
      checks++;
      if (transfer !== 1'b1 || apb_read_paddr !== 9'h033) begin
         errors++; $display("FAIL midrst_reserve: got transfer=%b ra=%h, expected 1 033", transfer, apb_read_paddr);
      end
      psel = 1; penable = 1; pready = 1; apb_read_data_out = 8'h5A;
      tick();
      checks++;
      if (done0 !== 1'b1 || rdata !== 8'h5A) begin
         errors++; $display("FAIL midrst_reserve_done: got done0=%b rdata=%h, expected 1 5a", done0, rdata);
      end
      apb_idle(); req0 = 0;
      tick();
   endtask

   task automatic test_timeout();
      int n;
      req0 = 1; rw0 = 1; addr0 = 9'h077;
      apb_read_data_out = 8'hC3;
      tick();
      psel = 1; penable = 1; pready = 0;
      n = 0;
`ifdef APB_ARB_TIMEOUT_EN
      while (transfer === 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (n !== 16) begin
         errors++; $display("FAIL timeout_cycles: got %0d issue cycles, expected 16", n);
      end
      checks++;
      if ({done0, err, rdata, transfer} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
         errors++; $display("FAIL timeout_done: got d0=%b err=%b rd=%h tr=%b, expected 1 1 00 0", done0, err, rdata, transfer);
      end
      apb_idle(); req0 = 0;
      tick();
      checks++;
      if (err !== 1'b0 || done0 !== 1'b0) begin
         errors++; $display("FAIL timeout_err_clear: got err=%b done0=%b, expected 0 0", err, done0);
      end
`else
      while (n < 40) begin tick(); n++; end
      checks++;
      if (transfer !== 1'b1 || done0 !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL no_timeout_hold: got transfer=%b done0=%b err=%b, expected 1 0 0", transfer, done0, err);
      end
      pready = 1;
      tick();
      checks++;
      if (done0 !== 1'b1 || rdata !== 8'hC3) begin
         errors++; $display("FAIL no_timeout_complete: got done0=%b rdata=%h, expected 1 c3", done0, rdata);
      end
      apb_idle(); req0 = 0;
      tick();
`endif
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_idle_completion();
      test_contention();
      test_reset_mid_issue();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
